// File: rtl/zbuf_tile_server.sv
// rtl/zbuf_tile_server.sv - single-tile depth store with read forwarding and fast-clear sweep (optional stats: ZBUF_STATS_EN)
module zbuf_tile_server #(
  parameter int DEPTH_BITS = 24,
  parameter int ADDR_BITS = 6,
  parameter logic [DEPTH_BITS-1:0] CLEAR_VALUE = {DEPTH_BITS{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DEPTH_BITS-1:0] resp_depth,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DEPTH_BITS-1:0] wr_depth,
  input  logic                  clear_req,
`ifdef ZBUF_STATS_EN
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes,
`endif
  output logic                  clear_busy
);

  localparam int ENTRIES = 1 << ADDR_BITS;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;
  localparam logic [ADDR_BITS-1:0] CNT_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [0:0]            r_state;
  logic [ADDR_BITS-1:0]  r_cnt;
  logic [DEPTH_BITS-1:0] r_mem [ENTRIES];
  logic                  r_resp_valid;
  logic [DEPTH_BITS-1:0] r_resp_depth;

  logic w_idle;
  logic w_rd_fire;
  logic w_wr_fire;
  logic w_fwd;

  assign w_idle     = (r_state == S_IDLE);
  assign wr_ready   = w_idle;
  assign rd_ready   = w_idle && (!r_resp_valid || resp_ready);
  assign w_rd_fire  = rd_valid && rd_ready;
  assign w_wr_fire  = wr_valid && wr_ready;
  assign w_fwd      = w_wr_fire && (wr_addr == rd_addr);
  assign clear_busy = (r_state == S_CLEAR);
  assign resp_valid = r_resp_valid;
  assign resp_depth = r_resp_depth;

  // Sweep sequencing: CLEAR walks every entry once, IDLE waits for a clear pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else if (r_state == S_CLEAR) begin
      r_cnt <= r_cnt + CNT_ONE;
      if (&r_cnt) begin
        r_state <= S_IDLE;
      end
    end else if (clear_req) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end
  end

  // Storage array: the sweep owns the write port while clearing, the depth-test stage otherwise
  always_ff @(posedge clk) begin
    if (!w_idle) begin
      r_mem[r_cnt] <= CLEAR_VALUE;
    end else if (w_wr_fire) begin
      r_mem[wr_addr] <= wr_depth;
    end
  end

  // Response register: loads on accept (forwarding a same-cycle write), holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_depth <= '0;
    end else if (w_rd_fire) begin
      r_resp_valid <= 1'b1;
      r_resp_depth <= w_fwd ? wr_depth : r_mem[rd_addr];
    end else if (resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

`ifdef ZBUF_STATS_EN
  logic [31:0] r_stat_reads;
  logic [31:0] r_stat_writes;

  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;

  // Saturating traffic counters; only a hard reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
    end else begin
      if (w_rd_fire && (r_stat_reads != 32'hFFFF_FFFF)) begin
        r_stat_reads <= r_stat_reads + 32'd1;
      end
      if (w_wr_fire && (r_stat_writes != 32'hFFFF_FFFF)) begin
        r_stat_writes <= r_stat_writes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/zbuf_tile_server.md
Name: zbuf_tile_server

Overview:
- On-chip depth-buffer tile store for one screen tile, sitting on the ROP side of the early-Z path.
- Answers stored-depth read requests and accepts depth write-backs from the depth-test stage.
- Provides a hardware fast-clear that sweeps the tile to a programmable clear depth.
- Read-after-write hazards within a cycle are resolved by forwarding.

Parameters:
- DEPTH_BITS, 24, width of one depth value.
- ADDR_BITS, 6, log2 of entries per tile (64 entries at default).
- CLEAR_VALUE, {DEPTH_BITS{1'b1}}, depth written by reset-clear and by clear_req.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_valid  input  1  read request valid.
- rd_ready  output  1  read request accepted when rd_valid && rd_ready.
- rd_addr  input  ADDR_BITS  entry to read.
- resp_valid  output  1  read response valid.
- resp_ready  input  1  consumer accepts response.
- resp_depth  output  DEPTH_BITS  stored depth for the accepted read.
- wr_valid  input  1  depth write valid.
- wr_ready  output  1  write accepted when wr_valid && wr_ready.
- wr_addr  input  ADDR_BITS  entry to write.
- wr_depth  input  DEPTH_BITS  depth to store.
- clear_req  input  1  single-cycle pulse requesting a full-tile clear.
- clear_busy  output  1  high while a clear sweep is in progress.

Behaviour:
- Reset: asynchronous, active-low; reset is one clock, rst_n.
- Outputs during reset: resp_valid=0, resp_depth=0, clear_busy=1; FSM forced to CLEAR with sweep counter 0. The tile is therefore cleared automatically after reset release.
- Reset mid-sweep or mid-transaction: restarts the sweep at entry 0 and drops any pending response.
- FSM states: CLEAR and IDLE.
- CLEAR:
  - Writes CLEAR_VALUE to entry[cnt] each cycle; cnt increments.
  - On cnt == 2^ADDR_BITS-1 the entry is written and the FSM moves to IDLE next cycle. A sweep is exactly 2^ADDR_BITS cycles.
  - clear_req is ignored while in CLEAR.
- IDLE: clear_req=1 moves the FSM to CLEAR with cnt=0 next cycle.
- clear_busy = (state == CLEAR).
- Ready signals (combinational):
  - wr_ready = (state == IDLE).
  - rd_ready = (state == IDLE) && (!resp_valid || resp_ready).
- Read latency:
  - An accepted read presents resp_valid=1 and resp_depth on the next cycle.
  - Back-to-back reads sustain 1 per cycle while resp_ready=1.
- Response stall: while resp_valid && !resp_ready, resp_depth holds stable and no new read is accepted.
- Response pop: resp_valid falls after a pop unless a new read is accepted in the same cycle.
- Write timing: an accepted write updates the entry at the clock edge.
- Same-cycle read and write to the same address: the response returns wr_depth (forwarded). Different addresses are independent.
- A response registered before a clear started remains valid and unchanged through the sweep.
- clear_req in the same cycle as an accepted write: the write commits, then the sweep overwrites it.
- No depth arithmetic is performed; the block is storage only. Addresses wrap only via the sweep counter.

Optional Feature:
- Macro ZBUF_STATS_EN.
- When defined, adds two outputs:
  - stat_reads  output  32: count of accepted reads.
  - stat_writes  output  32: count of accepted writes.
- Both counters reset to 0 only by rst_n (not by clear_req) and saturate at 32'hFFFF_FFFF.
- When undefined, both ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release with all inputs low:
  - clear_busy=1 for exactly 64 cycles, then 0.
  - Subsequent read of addr 5 returns 24'hFFFFFF one cycle after accept.
- Write addr 3 = 24'h000100, then read addr 3 next cycle → resp_depth = 24'h000100.
- Same cycle: write addr 7 = 24'h0000AA and read addr 7 → response = 24'h0000AA.
- Read accepted with resp_ready=0 for 4 cycles:
  - resp_depth stable, rd_ready=0.
  - resp_ready=1 pops it, and a new read is accepted in that same cycle.
- Write addr 10 = 24'h000001, pulse clear_req:
  - rd_ready and wr_ready are 0 for 64 cycles.
  - A read of addr 10 then returns 24'hFFFFFF.
- ZBUF_STATS_EN defined, 3 reads and 2 writes accepted → stat_reads=3, stat_writes=2; both are unchanged after a clear_req.
